// File: rtl/sha512_padder.sv
// SHA-512 message padder: packs a big-endian 64-bit word stream into 1024-bit
// blocks, appends the 0x80 marker, zero fill and the 128-bit message bit-length.
module sha512_padder #(
  parameter int LEN_WIDTH = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   in_data,
  input  logic [3:0]    in_nbytes,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [1023:0] M_out,
  output logic          M_valid,
  input  logic          M_ready,
  output logic          M_first,
  output logic          M_last
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    PAD  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             widx_q, widx_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic                   first_q, first_d;
  logic                   pend_q, pend_d;
  logic                   pad80_q, pad80_d;
  logic [1023:0]          blk_q, blk_d;
  logic                   in_ready_q, in_ready_d;
  logic                   m_valid_q, m_valid_d;
  logic                   m_first_q, m_first_d;
  logic                   m_last_q, m_last_d;

  logic [63:0]            word_m_s;
  logic [LEN_WIDTH-1:0]   len_sum_s;
  logic [127:0]           len_field_s;
  logic [127:0]           pad_len_s;
  logic [7:0]             b_s;

  // Keep only the left-justified valid bytes of an input word.
  function automatic logic [63:0] mask_word(input logic [63:0] d, input logic [3:0] nb);
    logic [63:0] m;
    m = 64'd0;
    for (int j = 0; j < 8; j++) begin
      if (4'(j) < nb) begin
        m[63-8*j -: 8] = d[63-8*j -: 8];
      end else begin
        m[63-8*j -: 8] = 8'h00;
      end
    end
    return m;
  endfunction

  assign word_m_s    = mask_word(in_data, in_nbytes);
  assign len_sum_s   = len_q + LEN_WIDTH'({in_nbytes, 3'b000});
  assign len_field_s = 128'(len_sum_s);
  assign pad_len_s   = 128'(len_q);
  assign b_s         = {1'b0, widx_q, 3'b000} + {4'b0000, in_nbytes};

  // Next-state, block assembly and registered-output decode.
  always_comb begin
    state_d   = state_q;
    widx_d    = widx_q;
    len_d     = len_q;
    first_d   = first_q;
    pend_d    = pend_q;
    pad80_d   = pad80_q;
    blk_d     = blk_q;
    m_last_d  = m_last_q;

    case (state_q)
      FILL: begin
        if (in_valid && in_ready_q) begin
          len_d = len_sum_s;
          for (int s = 0; s < 16; s++) begin
            if (widx_q == 4'(s)) begin
              blk_d[1023-64*s -: 64] = word_m_s;
            end else begin
              blk_d[1023-64*s -: 64] = blk_q[1023-64*s -: 64];
            end
          end
          if (!in_last) begin
            if (widx_q == 4'd15) begin
              state_d  = HOLD;
              m_last_d = 1'b0;
            end else begin
              widx_d = widx_q + 4'd1;
            end
          end else begin
            // Bytes below b hold message data; b gets the marker when it fits.
            for (int k = 0; k < 112; k++) begin
              if (8'(k) == b_s) begin
                blk_d[1023-8*k -: 8] = 8'h80;
              end else if (8'(k) > b_s) begin
                blk_d[1023-8*k -: 8] = 8'h00;
              end else begin
                blk_d[1023-8*k -: 8] = blk_d[1023-8*k -: 8];
              end
            end
            for (int j = 0; j < 16; j++) begin
              if (8'(112 + j) == b_s) begin
                blk_d[127-8*j -: 8] = 8'h80;
              end else if (8'(112 + j) > b_s) begin
                blk_d[127-8*j -: 8] = (b_s <= 8'd111) ? len_field_s[127-8*j -: 8] : 8'h00;
              end else begin
                blk_d[127-8*j -: 8] = blk_d[127-8*j -: 8];
              end
            end
            state_d = HOLD;
            if (b_s <= 8'd111) begin
              m_last_d = 1'b1;
              pend_d   = 1'b0;
              pad80_d  = 1'b1;
            end else begin
              m_last_d = 1'b0;
              pend_d   = 1'b1;
              pad80_d  = (b_s != 8'd128);
            end
          end
        end else begin
          state_d = FILL;
        end
      end

      HOLD: begin
        if (M_ready) begin
          first_d  = 1'b0;
          widx_d   = 4'd0;
          m_last_d = 1'b0;
          if (pend_q) begin
            state_d = PAD;
          end else if (m_last_q) begin
            len_d   = '0;
            first_d = 1'b1;
            state_d = FILL;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = HOLD;
        end
      end

      PAD: begin
        blk_d = 1024'd0;
        if (!pad80_q) begin
          blk_d[1023:1016] = 8'h80;
        end else begin
          blk_d[1023:1016] = 8'h00;
        end
        blk_d[127:0] = pad_len_s;
        pend_d   = 1'b0;
        pad80_d  = 1'b1;
        m_last_d = 1'b1;
        state_d  = HOLD;
      end

      default: begin
        state_d = FILL;
      end
    endcase

    in_ready_d = (state_d == FILL);
    m_valid_d  = (state_d == HOLD);
    m_first_d  = (state_d == HOLD) && first_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      widx_q     <= 4'd0;
      len_q      <= '0;
      first_q    <= 1'b1;
      pend_q     <= 1'b0;
      pad80_q    <= 1'b0;
      blk_q      <= 1024'd0;
      in_ready_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_first_q  <= 1'b0;
      m_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      len_q      <= len_d;
      first_q    <= first_d;
      pend_q     <= pend_d;
      pad80_q    <= pad80_d;
      blk_q      <= blk_d;
      in_ready_q <= in_ready_d;
      m_valid_q  <= m_valid_d;
      m_first_q  <= m_first_d;
      m_last_q   <= m_last_d;
    end
  end

  assign in_ready = in_ready_q;
  assign M_out    = blk_q;
  assign M_valid  = m_valid_q;
  assign M_first  = m_first_q;
  assign M_last   = m_last_q;

endmodule

// File: tb/tb_sha512_padder.sv
// Randomized bench for sha512_padder: expected blocks come from a byte-level
// padding model (append 0x80, zero to 112 mod 128, append 128-bit bit length).
module tb_sha512_padder;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   in_data = 64'd0;
  logic [3:0]    in_nbytes = 4'd0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1023:0] M_out;
  logic          M_valid;
  logic          M_ready = 1'b0;
  logic          M_first;
  logic          M_last;

  int n_cmp = 0;
  int n_err = 0;
  int stall_req = 0;
  int stalls_done = 0;

  logic [7:0]    msg_q[$];
  logic [1023:0] exp_blk[$];
  logic          exp_first[$];
  logic          exp_last[$];

  sha512_padder #(.LEN_WIDTH(128)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_nbytes(in_nbytes), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .M_out(M_out), .M_valid(M_valid), .M_ready(M_ready),
    .M_first(M_first), .M_last(M_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: pad the byte string, split it into blocks with first/last flags.
  task automatic build_expected();
    logic [7:0]    p[$];
    logic [127:0]  bits;
    logic [1023:0] blk;
    int            nblk;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 128 != 112) p.push_back(8'h00);
    bits = 128'(msg_q.size()) * 128'd8;
    for (int i = 0; i < 16; i++) p.push_back(bits[127-8*i -: 8]);
    nblk = p.size() / 128;
    for (int b = 0; b < nblk; b++) begin
      blk = 1024'd0;
      for (int k = 0; k < 128; k++) blk[1023-8*k -: 8] = p[128*b + k];
      exp_blk.push_back(blk);
      exp_first.push_back(b == 0);
      exp_last.push_back(b == nblk - 1);
    end
  endtask

  task automatic drive_word(input logic [63:0] d, input logic [3:0] nb, input logic last);
    int g;
    g = 0;
    while ($urandom_range(3) == 0) @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_nbytes = nb;
    in_last   = last;
    while (!in_ready && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check_eq("in_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = {$urandom, $urandom};
    in_nbytes = 4'($urandom_range(8));
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_blk.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check_eq("drain", 64'(exp_blk.size()), 64'd0);
  endtask

  task automatic send_msg();
    int n, nw, nb;
    bit extra;
    logic [63:0] d;
    build_expected();
    n  = msg_q.size();
    nw = (n + 7) / 8;
    extra = (n == 0) || ((n % 8 == 0) && ($urandom_range(1) == 1));
    for (int i = 0; i < nw; i++) begin
      nb = (n - 8*i > 8) ? 8 : n - 8*i;
      d  = {$urandom, $urandom};
      for (int j = 0; j < nb; j++) d[63-8*j -: 8] = msg_q[8*i + j];
      drive_word(d, 4'(nb), (i == nw - 1) && !extra);
    end
    if (extra) drive_word({$urandom, $urandom}, 4'd0, 1'b1);
    wait_drain();
  endtask

  task automatic rand_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  // Output sink: checks every held block against the model and applies backpressure.
  always @(negedge clk) begin
    logic [1023:0] e;
    if (!rst) begin
      if (exp_blk.size() == 0) begin
        check_eq("spurious_valid", 64'(M_valid), 64'd0);
        M_ready = 1'($urandom_range(1));
      end else if (M_valid) begin
        e = exp_blk[0];
        for (int w = 0; w < 16; w++)
          check_eq($sformatf("m_out_w%0d", w), M_out[1023-64*w -: 64], e[1023-64*w -: 64]);
        check_eq("m_first", 64'(M_first), 64'(exp_first[0]));
        check_eq("m_last", 64'(M_last), 64'(exp_last[0]));
        check_eq("in_ready_hold", 64'(in_ready), 64'd0);
        if (stall_req != 0 && stalls_done < 5) begin
          M_ready = 1'b0;
          stalls_done++;
        end else begin
          M_ready = ($urandom_range(3) != 0);
        end
        if (M_ready) begin
          void'(exp_blk.pop_front());
          void'(exp_first.pop_front());
          void'(exp_last.pop_front());
        end
      end else begin
        M_ready = 1'($urandom_range(1));
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_m_valid", 64'(M_valid), 64'd0);
    check_eq("rst_m_first", 64'(M_first), 64'd0);
    check_eq("rst_m_last", 64'(M_last), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    for (int w = 0; w < 16; w++) check_eq("rst_m_out", M_out[1023-64*w -: 64], 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("in_ready_after_rst", 64'(in_ready), 64'd1);

    msg_q.delete();
    send_msg();
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg();
    rand_msg(111);
    send_msg();
    rand_msg(112);
    send_msg();
    stall_req = 1;
    rand_msg(128);
    send_msg();
    stall_req = 0;

    for (int i = 0; i < 5; i++) drive_word({$urandom, $urandom}, 4'd8, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_m_valid", 64'(M_valid), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg();

    for (int i = 0; i < 40; i++) begin
      rand_msg($urandom_range(300));
      send_msg();
    end
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
